// File: rtl/pipe_pkg.sv
// Shared definitions for the memory-stage pipeline buffer: default sizing and
// the memory-stage payload record that callers flatten onto in_data.
package pipe_pkg;

   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_DEPTH  = 2;

   typedef struct packed {
      logic [31:0] nPC;
      logic        regWr;
      logic [1:0]  regSel;
      logic [4:0]  regDst;
      logic [31:0] ALUOut;
      logic        halt;
      logic [31:0] dmemstore;
      logic [31:0] lui;
      logic        dREN;
      logic        dWEN;
   } mem_payload_t;

   localparam int MEM_PAYLOAD_W = $bits(mem_payload_t);

   function automatic logic [MEM_PAYLOAD_W-1:0] flatten_mem_payload(input mem_payload_t p);
      return p;
   endfunction

   function automatic mem_payload_t unflatten_mem_payload(input logic [MEM_PAYLOAD_W-1:0] v);
      return mem_payload_t'(v);
   endfunction

   // Pointer wrap relies on a power-of-two depth of at least two.
   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/pipe_stage_fifo_if.sv
// Handshake bundle between a producer, the stage buffer and its consumer.
interface pipe_stage_fifo_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int DEPTH  = PIPE_DEPTH
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  count;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );

endinterface

// File: rtl/pipe_ptr.sv
// Wrapping index register for the stage buffer; reset and clear both return it to 0.
module pipe_ptr
   import pipe_pkg::*;
#(
   parameter int DEPTH = PIPE_DEPTH
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     clear,
   input  logic                     inc,
   output logic [$clog2(DEPTH)-1:0] ptr
);

   localparam int               PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_fifo.sv
// Registered pipeline-stage buffer: DEPTH-entry FIFO with valid/ready on both
// sides, one-cycle latency, flush, and masked output when empty.
module pipe_stage_fifo
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int DEPTH  = PIPE_DEPTH
) (
   input logic              CLK,
   input logic              RST,
   pipe_stage_fifo_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("pipe_stage_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   // Ready and valid come only from the registered occupancy, so a pop can
   // never open room for a push in the same cycle.
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.in_valid & ~full & ~bus.flush;
   assign pop   = bus.out_ready & ~empty & ~bus.flush;

   pipe_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .CLK   (CLK),
      .RST   (RST),
      .clear (bus.flush),
      .inc   (push),
      .ptr   (wr_ptr)
   );

   pipe_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .CLK   (CLK),
      .RST   (RST),
      .clear (bus.flush),
      .inc   (pop),
      .ptr   (rd_ptr)
   );

   // Storage is never cleared; occupancy alone decides what is visible.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || bus.flush) begin
         count_q <= '0;
      end else begin
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.in_ready  = ~full;
   assign bus.out_valid = ~empty;
   assign bus.out_data  = empty ? '0 : mem[rd_ptr];
   assign bus.count     = count_q;

endmodule

// File: doc/pipe_stage_fifo.md
PIPE_STAGE_FIFO -- requirements
Module: pipe_stage_fifo

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits, range 1..256.
REQ-002 Parameter DEPTH, default 2: stage buffer entries; power of two, at least 2.
REQ-003 Port CLK, input, 1: single clock; all state updates on posedge CLK.
REQ-004 Port RST, input, 1: reset, synchronous and active-high.
REQ-005 Port flush, input, 1: discards all buffered entries.
REQ-006 Port in_valid, input, 1: upstream presents a payload.
REQ-007 Port in_ready, output, 1: stage accepts a payload this cycle.
REQ-008 Port in_data, input, DATA_W: upstream payload.
REQ-009 Port out_valid, output, 1: head entry is available downstream.
REQ-010 Port out_ready, input, 1: downstream consumes the head entry this cycle.
REQ-011 Port out_data, output, DATA_W: head entry payload.
REQ-012 Port count, output, $clog2(DEPTH+1): number of occupied entries.

Function
REQ-013 Push occurs when in_valid and in_ready are both high at posedge CLK, and flush is low.
REQ-014 Pop occurs when out_valid and out_ready are both high at posedge CLK, and flush is low.
REQ-015 in_ready = (count < DEPTH), driven from registered state only; when full, no push occurs even if a pop occurs in the same cycle.
REQ-016 out_valid = (count != 0); out_data = head entry when out_valid is high, otherwise all zeros.
REQ-017 Latency is exactly one cycle: a payload pushed at edge N is visible on out_data after edge N, with no combinational in-to-out path.
REQ-018 Simultaneous push and pop when 0 < count < DEPTH leaves count unchanged and preserves FIFO order.
REQ-019 Write and read pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no lost or duplicated entry.
REQ-020 count updates as follows: push only, +1; pop only, -1; both or neither, unchanged. count never exceeds DEPTH and never underflows.
REQ-021 When flush is high at posedge CLK, the block clears count and both pointers, ignores push and pop that cycle, and drives out_valid=0 and in_ready=1 from the next cycle.
REQ-022 flush and RST assertion in the same cycle produce the reset state.
REQ-023 out_data and out_valid hold stable while out_valid=1 and out_ready=0; a stalled head is not altered by pushes.
REQ-024 Storage contents are not cleared by flush or reset; only occupancy state is cleared, and out_data is masked per REQ-016.

Reset
REQ-025 On RST high at posedge CLK: count=0, write pointer=0, read pointer=0.
REQ-026 During and after reset: out_valid=0, out_data=0, in_ready=1.
REQ-027 Reset asserted mid-stream discards all entries, and no pending payload appears at the output afterward.

Structure
REQ-028 Shared package pipe_pkg holds the DATA_W and DEPTH defaults and the memory-stage payload packed struct typedef (nPC, regWr, regSel, regDst, ALUOut, halt, dmemstore, lui, dREN, dWEN), which callers flatten onto in_data.
REQ-029 One sub-module, pipe_ptr: a wrapping pointer register with RST, clear and increment inputs, instantiated once for the write pointer and once for the read pointer.
REQ-030 Storage is a DEPTH x DATA_W register array inside pipe_stage_fifo, and no memory macro is used.

Verification
REQ-031 Reset and idle, DEPTH=2: assert RST 2 cycles -> count=0, out_valid=0, out_data=0, in_ready=1.
REQ-032 Fill and stall, DEPTH=2, out_ready=0: push 0xA1 then 0xB2 -> count=2, in_ready=0; a third in_valid with 0xC3 is dropped; out_data stays 0xA1.
REQ-033 Streaming, DEPTH=4, in_valid=out_ready=1: push 0x10..0x19 -> outputs 0x10..0x19 in order, each one cycle after push; count steady at 1; pointers wrap twice.
REQ-034 Full with pop, DEPTH=2: count=2 and out_ready=1 with in_valid=1 -> pop only, count=1, in_ready=1 next cycle.
REQ-035 Flush with push, count=3, DEPTH=4: flush=1, in_valid=1, out_ready=1 -> next cycle count=0, out_valid=0, pushed payload absent.
REQ-036 Reset priority: RST=1 and flush=0 with count=2 and a simultaneous push -> count=0, and the output stays empty until a new push.
